dmem_host_loader: RTL and testbench
===================================

DMEM_HOST_LOADER -- requirements
Module: dmem_host_loader

Interface
REQ-001 SHALL have parameter RUN_W, default 16, meaning the width of the CPU run-cycle counter.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port start  input  1  one-cycle pulse that begins a load/run/dump session; sampled only in IDLE.
REQ-005 SHALL have ports base_addr  input  32 and num_words  input  16: the word-aligned byte address and word count for load and dump; both latched on start.
REQ-006 SHALL have port run_cycles  input  RUN_W  the number of cycles the CPU runs; latched on start.
REQ-007 SHALL have ports ld_valid  input  1, ld_data  input  32 and ld_ready  output  1, forming the load word stream.
REQ-008 SHALL have ports dp_valid  output  1, dp_data  output  32 and dp_ready  input  1, forming the dump word stream.
REQ-009 SHALL have ports cpu_rst  output  1, ext_memwr_sgn  output  1, ext_datamem_wr  output  32 (write byte address), ext_wr_data  output  32, ext_datamem_rd  output  32 (read byte address) and read_data  input  32 (combinational data-memory read data).
REQ-010 SHALL have ports busy  output  1 and done  output  1 (one-cycle pulse at session end).

Function
REQ-011 SHALL implement the states IDLE, LOAD, RUN, HALT, DUMP and FIN.
REQ-012 IDLE: on start with num_words != 0 -> LOAD; on start with num_words == 0 -> RUN; otherwise stay.
REQ-013 LOAD: ld_ready SHALL be 1; on ld_valid&ld_ready the block SHALL drive ext_memwr_sgn=1, ext_datamem_wr=base_addr+4*idx and ext_wr_data=ld_data in that same cycle, then increment idx; the transfer with idx == num_words-1 -> RUN.
REQ-014 ext_memwr_sgn SHALL be 1 only in a LOAD-state handshake cycle and 0 in every other cycle.
REQ-015 cpu_rst SHALL be 1 in every state except RUN.
REQ-016 RUN: a down-counter SHALL load run_cycles on entry and decrement each cycle; when it reaches 0 the state SHALL go to HALT, so cpu_rst=0 for exactly run_cycles cycles; run_cycles == 0 -> HALT after 1 cycle.
REQ-017 HALT: one cycle with cpu_rst=1, then -> DUMP if num_words != 0, else -> FIN.
REQ-018 DUMP: ext_datamem_rd SHALL be base_addr+4*idx; when dp_valid==0, read_data SHALL be registered into dp_data and dp_valid set on the next edge; dp_data/dp_valid SHALL hold until dp_ready; on dp_valid&dp_ready idx increments; the last accepted word -> FIN.
REQ-019 Simultaneous handshake and reload: in the cycle dp_valid&dp_ready is true, the next word SHALL NOT be captured; maximum throughput is one word per 2 cycles.
REQ-020 FIN: done=1 for one cycle, then -> IDLE.
REQ-021 busy SHALL be 1 in every state except IDLE.
REQ-022 Address arithmetic SHALL be 32-bit modulo, wrapping silently past 0xFFFF_FFFC.
REQ-023 start outside IDLE SHALL be ignored.
REQ-024 ext_datamem_rd SHALL be base_addr in all states other than DUMP.

Reset
REQ-025 rst=1 SHALL asynchronously force IDLE, idx=0, counter=0, cpu_rst=1, ext_memwr_sgn=0, ld_ready=0, dp_valid=0, dp_data=0, ext_datamem_wr=0, ext_wr_data=0, ext_datamem_rd=0, busy=0, done=0.
REQ-026 rst asserted mid-session SHALL abort the session with no further memory writes; after release the block SHALL be in IDLE awaiting start.

Configuration
REQ-027 When DMEM_LOADER_CHECKSUM_EN is defined, the block SHALL add outputs ld_sum[31:0] and dp_sum[31:0]: modulo-2^32 sums of accepted load and dump words, cleared on start and by rst, valid when done pulses.
REQ-028 When DMEM_LOADER_CHECKSUM_EN is undefined, the block SHALL have neither those ports nor their logic.

Verification
REQ-029 base=0x100, num_words=3, run_cycles=5, ld_data 0xA,0xB,0xC -> writes to 0x100/0x104/0x108; cpu_rst low exactly 5 cycles; 3 dump words read from the same addresses.
REQ-030 dp_ready held 0 for 10 cycles during DUMP -> dp_data/dp_valid stable, ext_datamem_rd unchanged.
REQ-031 num_words=0, run_cycles=4 -> no ext_memwr_sgn pulse, cpu_rst low 4 cycles, no dp_valid, done pulses.
REQ-032 base=0xFFFF_FFFC, num_words=2 -> second write address 0x0000_0000.
REQ-033 rst pulsed after 1 of 3 loads -> exactly one ext_memwr_sgn pulse; outputs at reset values; new start works.
REQ-034 With DMEM_LOADER_CHECKSUM_EN defined, load 0xFFFF_FFFF,0x2 -> ld_sum=0x1; dump of the same memory -> dp_sum=0x1.

Source files
------------

// File: rtl/dmem_host_loader.sv
// dmem_host_loader: host-side sequencer for a CPU data memory.
// One session loads num_words words from the ld_* stream into memory at
// base_addr, releases the CPU from reset for run_cycles cycles, then reads
// the same words back out on the dp_* stream.
// Optional feature: define DMEM_LOADER_CHECKSUM_EN to add ld_sum/dp_sum outputs
// (modulo-2^32 sums of accepted load and dump words).
module dmem_host_loader #(
  parameter int RUN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [15:0]      num_words,
  input  logic [RUN_W-1:0] run_cycles,
  input  logic             ld_valid,
  input  logic [31:0]      ld_data,
  output logic             ld_ready,
  output logic             dp_valid,
  output logic [31:0]      dp_data,
  input  logic             dp_ready,
  output logic             cpu_rst,
  output logic             ext_memwr_sgn,
  output logic [31:0]      ext_datamem_wr,
  output logic [31:0]      ext_wr_data,
  output logic [31:0]      ext_datamem_rd,
  input  logic [31:0]      read_data,
  output logic             busy,
  output logic             done
`ifdef DMEM_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]      ld_sum,
  output logic [31:0]      dp_sum
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_HALT,
    S_DUMP,
    S_FIN
  } state_t;

  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

  state_t           state;
  state_t           state_nxt;

  // Session parameters captured on start so the host may change its inputs.
  logic [31:0]      base_q;
  logic [15:0]      num_q;
  logic [RUN_W-1:0] run_q;

  // Word index shared by the load and dump phases; run-phase down-counter.
  logic [15:0]      idx;
  logic [RUN_W-1:0] counter;

  logic             ld_hs;
  logic             dp_hs;
  logic             idx_last;
  logic [31:0]      idx_addr;

  // Handshake qualifiers and the word address for the current index.
  // The address sum is 32 bits wide, so it wraps past 0xFFFF_FFFC by itself.
  assign ld_hs    = (state == S_LOAD) && ld_valid;
  assign dp_hs    = (state == S_DUMP) && dp_valid && dp_ready;
  assign idx_last = (idx == (num_q - 16'd1));
  assign idx_addr = base_q + {14'b0, idx, 2'b00};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked state uses <= so every register samples pre-edge values;
    // a blocking = here would let later statements see the updated value.
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and all Moore/Mealy outputs.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_nxt      = state;
    ld_ready       = 1'b0;
    cpu_rst        = 1'b1;
    busy           = 1'b1;
    done           = 1'b0;
    ext_memwr_sgn  = 1'b0;
    ext_wr_data    = 32'h0;
    ext_datamem_wr = 32'h0;
    ext_datamem_rd = base_q;

    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt = (num_words != 16'd0) ? S_LOAD : S_RUN;
        end
      end

      S_LOAD: begin
        ld_ready       = 1'b1;
        ext_datamem_wr = idx_addr;
        if (ld_hs) begin
          ext_memwr_sgn = 1'b1;
          ext_wr_data   = ld_data;
          if (idx_last) begin
            state_nxt = S_RUN;
          end
        end
      end

      S_RUN: begin
        cpu_rst = 1'b0;
        // The counter holds the cycles still to run including this one.
        if (counter <= RUN_ONE) begin
          state_nxt = S_HALT;
        end
      end

      S_HALT: begin
        state_nxt = (num_q != 16'd0) ? S_DUMP : S_FIN;
      end

      S_DUMP: begin
        ext_datamem_rd = idx_addr;
        if (dp_hs && idx_last) begin
          state_nxt = S_FIN;
        end
      end

      S_FIN: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Session parameters, word index, run counter and the dump output register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the dump register and address sources are reset as well, because
    // the memory-side outputs must read as zero while rst is held.
    if (rst) begin
      base_q   <= 32'h0;
      num_q    <= 16'd0;
      run_q    <= '0;
      idx      <= 16'd0;
      counter  <= '0;
      dp_valid <= 1'b0;
      dp_data  <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            base_q <= base_addr;
            num_q  <= num_words;
            run_q  <= run_cycles;
            idx    <= 16'd0;
            // With nothing to load the run phase starts on the next edge.
            if (num_words == 16'd0) begin
              counter <= run_cycles;
            end
          end
        end

        S_LOAD: begin
          if (ld_hs) begin
            if (idx_last) begin
              idx     <= 16'd0;
              counter <= run_q;
            end else begin
              idx <= idx + 16'd1;
            end
          end
        end

        S_RUN: begin
          if (counter != '0) begin
            counter <= counter - RUN_ONE;
          end
        end

        S_HALT: begin
          idx <= 16'd0;
        end

        S_DUMP: begin
          // A word is captured only while the output slot is empty, so the
          // handshake cycle never reloads and throughput is one word per two
          // cycles.
          if (dp_hs) begin
            dp_valid <= 1'b0;
            idx      <= idx + 16'd1;
          end else if (!dp_valid) begin
            dp_data  <= read_data;
            dp_valid <= 1'b1;
          end
        end

        default: begin
        end
      endcase
    end
  end

`ifdef DMEM_LOADER_CHECKSUM_EN
  // Running sums of accepted load and dump words, cleared on session start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_sum <= 32'h0;
      dp_sum <= 32'h0;
    end else if ((state == S_IDLE) && start) begin
      ld_sum <= 32'h0;
      dp_sum <= 32'h0;
    end else begin
      if (ld_hs) begin
        ld_sum <= ld_sum + ld_data;
      end
      if (dp_hs) begin
        dp_sum <= dp_sum + dp_data;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_host_loader.sv
// Self-checking bench for dmem_host_loader: table-driven sessions plus
// hand-written sequences for dump back-pressure, reset mid-load and,
// when DMEM_LOADER_CHECKSUM_EN is defined, the checksum outputs.
module tb_dmem_host_loader;

  localparam int RUN_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [31:0]      base_addr;
  logic [15:0]      num_words;
  logic [RUN_W-1:0] run_cycles;
  logic             ld_valid;
  logic [31:0]      ld_data;
  logic             ld_ready;
  logic             dp_valid;
  logic [31:0]      dp_data;
  logic             dp_ready;
  logic             cpu_rst;
  logic             ext_memwr_sgn;
  logic [31:0]      ext_datamem_wr;
  logic [31:0]      ext_wr_data;
  logic [31:0]      ext_datamem_rd;
  logic [31:0]      read_data;
  logic             busy;
  logic             done;
`ifdef DMEM_LOADER_CHECKSUM_EN
  logic [31:0]      ld_sum;
  logic [31:0]      dp_sum;
`endif

  always #5 clk = ~clk;

  dmem_host_loader #(.RUN_W(RUN_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .base_addr      (base_addr),
    .num_words      (num_words),
    .run_cycles     (run_cycles),
    .ld_valid       (ld_valid),
    .ld_data        (ld_data),
    .ld_ready       (ld_ready),
    .dp_valid       (dp_valid),
    .dp_data        (dp_data),
    .dp_ready       (dp_ready),
    .cpu_rst        (cpu_rst),
    .ext_memwr_sgn  (ext_memwr_sgn),
    .ext_datamem_wr (ext_datamem_wr),
    .ext_wr_data    (ext_wr_data),
    .ext_datamem_rd (ext_datamem_rd),
    .read_data      (read_data),
    .busy           (busy),
    .done           (done)
`ifdef DMEM_LOADER_CHECKSUM_EN
    ,
    .ld_sum         (ld_sum),
    .dp_sum         (dp_sum)
`endif
  );

  // Data memory model: 256 words, synchronous write, combinational read.
  // Unwritten words hold a recognisable per-address pattern.
  logic [31:0] mem [256];
  assign read_data = mem[ext_datamem_rd[9:2]];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hDEAD_0000 | 32'(i);
    end else if (ext_memwr_sgn) begin
      mem[ext_datamem_wr[9:2]] <= ext_wr_data;
    end
  end

  // Monitor: monotonic counters and logs, sampled mid-cycle.
  int          wr_cnt   = 0;
  int          low_cnt  = 0;
  int          done_cnt = 0;
  int          dpv_cnt  = 0;
  logic [31:0] wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  logic [31:0] dp_q      [$];

  always @(negedge clk) begin
    if (ext_memwr_sgn) begin
      wr_cnt++;
      wr_addr_q.push_back(ext_datamem_wr);
      wr_data_q.push_back(ext_wr_data);
    end
    if (!cpu_rst) low_cnt++;
    if (done) done_cnt++;
    if (dp_valid) dpv_cnt++;
    if (dp_valid && dp_ready) dp_q.push_back(dp_data);
  end

  int total = 0;
  int bad   = 0;

  // Load-word pattern for the current session.
  logic [31:0] pat [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fill_pat(input logic [31:0] seed);
    for (int i = 0; i < 16; i++) pat[i] = seed + 32'(i);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " busy"},           32'(busy),          32'h0);
    check({tag, " done"},           32'(done),          32'h0);
    check({tag, " cpu_rst"},        32'(cpu_rst),       32'h1);
    check({tag, " ld_ready"},       32'(ld_ready),      32'h0);
    check({tag, " ext_memwr_sgn"},  32'(ext_memwr_sgn), 32'h0);
    check({tag, " dp_valid"},       32'(dp_valid),      32'h0);
    check({tag, " dp_data"},        dp_data,            32'h0);
    check({tag, " ext_datamem_wr"}, ext_datamem_wr,     32'h0);
    check({tag, " ext_wr_data"},    ext_wr_data,        32'h0);
    check({tag, " ext_datamem_rd"}, ext_datamem_rd,     32'h0);
  endtask

  // Called at posedge+1; returns at posedge+1 one cycle later with start low
  // and the parameter inputs scrambled, so only latched values can be used.
  task automatic pulse_start(input logic [31:0] base, input logic [15:0] n,
                             input logic [RUN_W-1:0] run);
    start      = 1'b1;
    base_addr  = base;
    num_words  = n;
    run_cycles = run;
    @(posedge clk); #1;
    start      = 1'b0;
    base_addr  = 32'hBAD0_0BA0;
    num_words  = 16'd7;
    run_cycles = RUN_W'(9);
  endtask

  // Runs one whole session; gap inserts idle cycles between ld_valid and
  // dp_ready assertions. Returns at posedge+1 after the done pulse.
  task automatic run_session(input logic [31:0] base, input logic [15:0] n,
                             input logic [RUN_W-1:0] run, input int gap);
    int cyc;
    int li;
    int d0;
    bit hs;
    d0 = done_cnt;
    pulse_start(base, n, run);
    cyc      = 0;
    li       = 0;
    ld_valid = (n != 16'd0);
    ld_data  = pat[0];
    dp_ready = (gap == 0);
    while (done_cnt == d0 && cyc < 400) begin
      @(negedge clk);
      hs = ld_valid && ld_ready;
      @(posedge clk); #1;
      if (hs) li++;
      cyc++;
      ld_valid = (li < int'(n)) && ((cyc % (gap + 1)) == 0);
      ld_data  = pat[li % 16];
      dp_ready = ((cyc % (gap + 1)) == gap);
    end
    ld_valid = 1'b0;
    dp_ready = 1'b0;
    check("session done seen", 32'(done_cnt != d0), 32'h1);
  endtask

  typedef struct {
    logic [31:0]      base;
    logic [15:0]      n;
    logic [RUN_W-1:0] run;
    int               gap;
    logic [31:0]      seed;
    logic [31:0]      first_wr;
    logic [31:0]      last_wr;
    int               exp_low;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, a0, l0, dn0, dq0, dv0, nw;
    int cyc, li;
    bit hs, stable;
    logic [31:0] hold_d, hold_a;

    vecs[0] = '{32'h0000_0100, 16'd3, RUN_W'(5), 0, 32'h0000_000A, 32'h0000_0100, 32'h0000_0108, 5};
    vecs[1] = '{32'h0000_0000, 16'd0, RUN_W'(4), 0, 32'h1111_0000, 32'h0,         32'h0,         4};
    vecs[2] = '{32'hFFFF_FFFC, 16'd2, RUN_W'(1), 1, 32'h2222_0000, 32'hFFFF_FFFC, 32'h0000_0000, 1};
    vecs[3] = '{32'h0000_0040, 16'd1, RUN_W'(0), 0, 32'h3333_0000, 32'h0000_0040, 32'h0000_0040, 1};
    vecs[4] = '{32'h0000_0200, 16'd4, RUN_W'(3), 2, 32'h4444_0000, 32'h0000_0200, 32'h0000_020C, 3};

    rst        = 1'b1;
    start      = 1'b0;
    base_addr  = 32'h0;
    num_words  = 16'd0;
    run_cycles = '0;
    ld_valid   = 1'b0;
    ld_data    = 32'h0;
    dp_ready   = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Table-driven sessions.
    for (int k = 0; k < 5; k++) begin
      fill_pat(vecs[k].seed);
      w0  = wr_cnt;
      a0  = wr_addr_q.size();
      l0  = low_cnt;
      dn0 = done_cnt;
      dq0 = dp_q.size();
      dv0 = dpv_cnt;
      run_session(vecs[k].base, vecs[k].n, vecs[k].run, vecs[k].gap);
      nw = int'(vecs[k].n);
      check($sformatf("v%0d write count", k), wr_cnt - w0, nw);
      if (nw > 0 && wr_addr_q.size() >= a0 + nw) begin
        check($sformatf("v%0d first write addr", k), wr_addr_q[a0], vecs[k].first_wr);
        check($sformatf("v%0d last write addr", k), wr_addr_q[a0 + nw - 1], vecs[k].last_wr);
        for (int i = 0; i < nw; i++)
          check($sformatf("v%0d write data %0d", k, i), wr_data_q[a0 + i], pat[i]);
      end
      check($sformatf("v%0d cpu_rst low cycles", k), low_cnt - l0, vecs[k].exp_low);
      check($sformatf("v%0d dump count", k), dp_q.size() - dq0, nw);
      if (dp_q.size() >= dq0 + nw) begin
        for (int i = 0; i < nw; i++)
          check($sformatf("v%0d dump data %0d", k, i), dp_q[dq0 + i], pat[i]);
      end
      check($sformatf("v%0d done pulses", k), done_cnt - dn0, 1);
      if (vecs[k].gap == 0)
        check($sformatf("v%0d dp_valid cycles", k), dpv_cnt - dv0, nw);
      @(negedge clk);
      check($sformatf("v%0d busy after", k), 32'(busy), 32'h0);
      check($sformatf("v%0d done after", k), 32'(done), 32'h0);
      @(posedge clk); #1;
    end

    // Back-pressure on the dump stream, with a start pulse that must be ignored.
    fill_pat(32'h5555_0000);
    dq0 = dp_q.size();
    dn0 = done_cnt;
    pulse_start(32'h300, 16'd2, RUN_W'(2));
    ld_valid = 1'b1;
    ld_data  = pat[0];
    dp_ready = 1'b0;
    li  = 0;
    cyc = 0;
    while (li < 2 && cyc < 20) begin
      @(negedge clk);
      hs = ld_valid && ld_ready;
      @(posedge clk); #1;
      if (hs) li++;
      ld_data  = pat[li % 16];
      ld_valid = (li < 2);
      cyc++;
    end
    check("stall load words", li, 2);
    cyc = 0;
    @(negedge clk);
    while (!dp_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("stall dp_valid seen", 32'(dp_valid), 32'h1);
    hold_d = dp_data;
    hold_a = ext_datamem_rd;
    check("stall first word", hold_d, pat[0]);
    check("stall read addr", hold_a, 32'h300);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (i == 3) begin
        start     = 1'b1;
        base_addr = 32'h700;
        num_words = 16'd5;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (!dp_valid || dp_data !== hold_d || ext_datamem_rd !== hold_a || !busy)
        stable = 1'b0;
    end
    start = 1'b0;
    check("stall outputs held", 32'(stable), 32'h1);
    @(posedge clk); #1;
    dp_ready = 1'b1;
    cyc = 0;
    while (done_cnt == dn0 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    dp_ready = 1'b0;
    check("stall done pulses", done_cnt - dn0, 1);
    check("stall dump count", dp_q.size() - dq0, 2);
    if (dp_q.size() >= dq0 + 2) begin
      check("stall dump word 0", dp_q[dq0], pat[0]);
      check("stall dump word 1", dp_q[dq0 + 1], pat[1]);
    end
    @(negedge clk);
    check("stall busy after", 32'(busy), 32'h0);
    @(posedge clk); #1;

    // Reset asserted after the first of three load words.
    fill_pat(32'h6666_0000);
    w0 = wr_cnt;
    pulse_start(32'h400, 16'd3, RUN_W'(5));
    ld_valid = 1'b1;
    ld_data  = pat[0];
    @(posedge clk); #1;
    ld_data = pat[1];
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    ld_valid = 1'b0;
    @(negedge clk);
    check("midrst write count", wr_cnt - w0, 1);
    check("midrst idle", 32'(busy), 32'h0);
    @(posedge clk); #1;
    fill_pat(32'h7777_0000);
    w0  = wr_cnt;
    dq0 = dp_q.size();
    run_session(32'h480, 16'd1, RUN_W'(2), 0);
    check("post-reset write count", wr_cnt - w0, 1);
    check("post-reset dump count", dp_q.size() - dq0, 1);
    if (dp_q.size() > dq0) check("post-reset dump data", dp_q[dq0], pat[0]);
    @(posedge clk); #1;

`ifdef DMEM_LOADER_CHECKSUM_EN
    // Checksums wrap modulo 2^32.
    pat[0] = 32'hFFFF_FFFF;
    pat[1] = 32'h0000_0002;
    run_session(32'h600, 16'd2, RUN_W'(1), 0);
    check("ld_sum", ld_sum, 32'h1);
    check("dp_sum", dp_sum, 32'h1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
